// File: rtl/axil_dma_csr_if.sv
// rtl/axil_dma_csr_if.sv - AXI-Lite response types and the CSR bus interface
package axi_pkg;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
endpackage

interface axil_dma_csr_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    axi_pkg::resp_t        bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    axi_pkg::resp_t        rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_dma_csr.sv
// rtl/axil_dma_csr.sv - AXI-Lite DMA control/status registers with start pulse and interrupt
module axil_dma_csr #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic               clk,
    input  logic               rst,
    axil_dma_csr_if.slave      s_axil,
    output logic               start_o,
    output logic [63:0]        src_addr_o,
    output logic [63:0]        dst_addr_o,
    output logic [31:0]        len_o,
    input  logic               busy_i,
    input  logic               done_i,
    output logic               irq_o
);
    import axi_pkg::*;

    logic                  r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_bvalid, r_rvalid;
    resp_t                 r_bresp, r_rresp;
    logic [31:0]           r_rdata;
    logic                  r_irq_en, r_done, r_err, r_start, r_irq;
    logic [31:0]           r_src_lo, r_src_hi, r_dst_lo, r_dst_hi, r_len;

    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [31:0]           w_wr_data;
    logic [3:0]            w_wr_strb;
    logic                  w_wr_mapped, w_rd_mapped;
    logic [2:0]            w_wr_idx, w_rd_idx;
    logic                  w_ctrl_wr, w_status_wr, w_start_req, w_done_clr, w_err_clr;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    assign s_axil.awready = ~r_aw_held & ~r_bvalid;
    assign s_axil.wready  = ~r_w_held & ~r_bvalid;
    assign s_axil.arready = ~r_rvalid;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rresp   = r_rresp;
    assign s_axil.rdata   = r_rdata;

    assign w_aw_hs = s_axil.awvalid & s_axil.awready;
    assign w_w_hs  = s_axil.wvalid & s_axil.wready;
    assign w_ar_hs = s_axil.arvalid & s_axil.arready;

    // A write commits as soon as both halves are present, whether captured earlier or arriving now
    assign w_commit  = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_wr_addr = r_aw_held ? r_aw_addr : s_axil.awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s_axil.wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axil.wstrb;

    assign w_wr_mapped = ~|w_wr_addr[ADDR_WIDTH-1:5];
    assign w_wr_idx    = w_wr_addr[4:2];
    assign w_rd_mapped = ~|s_axil.araddr[ADDR_WIDTH-1:5];
    assign w_rd_idx    = s_axil.araddr[4:2];

    assign w_ctrl_wr   = w_commit & w_wr_mapped & (w_wr_idx == 3'd0) & w_wr_strb[0];
    assign w_status_wr = w_commit & w_wr_mapped & (w_wr_idx == 3'd1) & w_wr_strb[0];
    assign w_start_req = w_ctrl_wr & w_wr_data[0];
    assign w_done_clr  = w_status_wr & w_wr_data[1];
    assign w_err_clr   = w_status_wr & w_wr_data[2];

    assign w_unused = &{1'b0, w_wr_addr[1:0], s_axil.araddr[1:0]};

    assign start_o    = r_start;
    assign irq_o      = r_irq;
    assign src_addr_o = {r_src_hi, r_src_lo};
    assign dst_addr_o = {r_dst_hi, r_dst_lo};
    assign len_o      = r_len;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        merge_lanes = old_val;
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (strb[i]) merge_lanes[8*i +: 8] = new_val[8*i +: 8];
        end
    endfunction

    always_comb begin
        w_rd_val = '0;
        if (w_rd_mapped) begin
            case (w_rd_idx)
                3'd0:    w_rd_val = {30'b0, r_irq_en, 1'b0};
                3'd1:    w_rd_val = {29'b0, r_err, r_done, busy_i};
                3'd2:    w_rd_val = r_src_lo;
                3'd3:    w_rd_val = r_src_hi;
                3'd4:    w_rd_val = r_dst_lo;
                3'd5:    w_rd_val = r_dst_hi;
                3'd6:    w_rd_val = r_len;
                default: w_rd_val = VERSION;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= s_axil.awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_axil.wdata;
                    r_wstrb  <= s_axil.wstrb;
                end
                if (s_axil.bready) r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_lo <= '0;
            r_src_hi <= '0;
            r_dst_lo <= '0;
            r_dst_hi <= '0;
            r_len    <= '0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_commit && w_wr_mapped) begin
                case (w_wr_idx)
                    3'd2:    r_src_lo <= merge_lanes(r_src_lo, w_wr_data, w_wr_strb);
                    3'd3:    r_src_hi <= merge_lanes(r_src_hi, w_wr_data, w_wr_strb);
                    3'd4:    r_dst_lo <= merge_lanes(r_dst_lo, w_wr_data, w_wr_strb);
                    3'd5:    r_dst_hi <= merge_lanes(r_dst_hi, w_wr_data, w_wr_strb);
                    3'd6:    r_len    <= merge_lanes(r_len, w_wr_data, w_wr_strb);
                    default: ;
                endcase
            end
            if (w_ctrl_wr) r_irq_en <= w_wr_data[1];
            // A start while the engine is busy is refused and flagged instead
            r_start <= w_start_req & ~busy_i;
            r_done  <= done_i | (r_done & ~w_done_clr);
            r_err   <= (w_start_req & busy_i) | (r_err & ~w_err_clr);
            r_irq   <= r_done & r_irq_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_val;
            r_rresp  <= w_rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil.rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_dma_csr.sv
// tb/tb_axil_dma_csr.sv - randomized bench for axil_dma_csr against a register-map model
module tb_axil_dma_csr;
    logic        clk;
    logic        rst;
    logic        start_o;
    logic [63:0] src_addr_o, dst_addr_o;
    logic [31:0] len_o;
    logic        busy_i, done_i, irq_o;

    axil_dma_csr_if #(.ADDR_WIDTH(8)) bus ();

    axil_dma_csr #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .VERSION(32'h0001_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axil     (bus),
        .start_o    (start_o),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .len_o      (len_o),
        .busy_i     (busy_i),
        .done_i     (done_i),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_checks = 0;

    // Register-map model: storage by word index, plus status bits and a start counter
    logic [31:0] m_reg [8];
    bit          m_irq_en, m_done, m_err;
    int          m_start_cnt = 0;
    int          cmp_start_seen = 0;
    bit          irq_pipe = 0;
    logic        s_awready, s_wready, s_arready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_irq_en = 0;
        m_done = 0;
        m_err = 0;
        irq_pipe = 0;
        cmp_start_seen = m_start_cnt;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        if (a >= 8'h20) return 32'h0;
        case (a[4:2])
            3'd0:    return {30'b0, m_irq_en, 1'b0};
            3'd1:    return {29'b0, m_err, m_done, busy_i};
            3'd7:    return 32'h0001_0000;
            default: return m_reg[a[4:2]];
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input bit busy);
        if (a >= 8'h20) return;
        case (a[4:2])
            3'd0: if (s[0]) begin
                m_irq_en = d[1];
                if (d[0]) begin
                    if (busy) m_err = 1;
                    else m_start_cnt++;
                end
            end
            3'd1: if (s[0]) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
            3'd7: ;
            default: for (int i = 0; i < 4; i++)
                if (s[i]) m_reg[a[4:2]][8*i +: 8] = d[8*i +: 8];
        endcase
    endtask

    // One clock: sample readies and compare the DUT outputs mid-cycle, then move past the edge
    task automatic tick();
        bit exp_start;
        @(negedge clk);
        s_awready = bus.awready;
        s_wready  = bus.wready;
        s_arready = bus.arready;
        exp_start = (m_start_cnt != cmp_start_seen);
        cmp_start_seen = m_start_cnt;
        chk("start_o", start_o, exp_start);
        chk("irq_o", irq_o, irq_pipe);
        irq_pipe = m_done & m_irq_en;
        chk("src_addr_o", src_addr_o, {m_reg[3], m_reg[2]});
        chk("dst_addr_o", dst_addr_o, {m_reg[5], m_reg[4]});
        chk("len_o", len_o, m_reg[6]);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input bit pulse_done);
        int  aw_at, w_at, cyc, hold;
        bit  aw_ok, w_ok;
        aw_at = (w_lead < 0) ? -w_lead : 0;
        w_at  = (w_lead > 0) ? w_lead : 0;
        aw_ok = 0; w_ok = 0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 40) begin
            if (cyc == aw_at) begin bus.awaddr = a; bus.awvalid = 1'b1; end
            if (cyc == w_at) begin bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; end
            if (cyc == 0 && pulse_done) done_i = 1'b1;
            tick();
            done_i = 1'b0;
            if (bus.awvalid && s_awready) begin aw_ok = 1; bus.awvalid = 1'b0; end
            if (bus.wvalid && s_wready) begin w_ok = 1; bus.wvalid = 1'b0; end
            if (w_ok && !aw_ok) chk("wready_while_w_held", bus.wready, 1'b0);
            cyc++;
        end
        if (!(aw_ok && w_ok)) begin
            chk("write_handshake_timeout", 1'b0, 1'b1);
            bus.awvalid = 1'b0;
            bus.wvalid = 1'b0;
            return;
        end
        chk("bvalid_latency", bus.bvalid, 1'b1);
        chk("bresp", bus.bresp, (a >= 8'h20) ? 2'b10 : 2'b00);
        chk("awready_during_b", bus.awready, 1'b0);
        chk("wready_during_b", bus.wready, 1'b0);
        model_write(a, d, s, busy_i);
        if (pulse_done) m_done = 1;
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            tick();
            chk("bvalid_hold", bus.bvalid, 1'b1);
            chk("awready_hold", bus.awready, 1'b0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bvalid_clear", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [7:0] a, input int rdelay, output logic [31:0] got);
        logic [31:0] exp;
        int          cyc;
        bit          ok;
        exp = model_read(a);
        bus.araddr = a;
        bus.arvalid = 1'b1;
        ok = 0; cyc = 0;
        got = '0;
        while (!ok && cyc < 40) begin
            tick();
            if (s_arready) begin ok = 1; bus.arvalid = 1'b0; end
            cyc++;
        end
        if (!ok) begin
            chk("read_handshake_timeout", 1'b0, 1'b1);
            bus.arvalid = 1'b0;
            return;
        end
        got = bus.rdata;
        chk("rvalid_latency", bus.rvalid, 1'b1);
        chk("rdata", bus.rdata, exp);
        chk("rresp", bus.rresp, (a >= 8'h20) ? 2'b10 : 2'b00);
        chk("arready_during_r", bus.arready, 1'b0);
        repeat (rdelay) begin
            tick();
            chk("rvalid_hold", bus.rvalid, 1'b1);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("rvalid_clear", bus.rvalid, 1'b0);
    endtask

    task automatic pulse_done_i();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        m_done = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          op;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        rst = 1'b1;
        busy_i = 1'b0; done_i = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_bvalid", bus.bvalid, 1'b0);
        chk("reset_rvalid", bus.rvalid, 1'b0);
        chk("reset_bresp", bus.bresp, 2'b00);
        chk("reset_rresp", bus.rresp, 2'b00);
        chk("reset_rdata", bus.rdata, 32'h0);
        tick();
        chk("reset_awready", bus.awready, 1'b1);
        chk("reset_wready", bus.wready, 1'b1);
        chk("reset_arready", bus.arready, 1'b1);

        axi_write(8'h08, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_write(8'h0C, 32'h0000_0001, 4'hF, 0, 0);
        chk("src_literal", src_addr_o, 64'h1_DEAD_BEEF);
        axi_read(8'h08, 0, got);
        chk("src_lo_literal", got, 32'hDEAD_BEEF);
        axi_read(8'h0C, 1, got);
        chk("src_hi_literal", got, 32'h0000_0001);

        axi_write(8'h18, 32'h1234_5678, 4'b0011, 3, 0);
        chk("len_literal", len_o, 32'h0000_5678);

        axi_write(8'h00, 32'h3, 4'h1, 0, 0);
        pulse_done_i();
        tick();
        chk("irq_literal_set", irq_o, 1'b1);
        axi_read(8'h04, 0, got);
        chk("status_done_literal", got, 32'h2);
        axi_write(8'h04, 32'h2, 4'h1, 0, 0);
        tick();
        chk("irq_literal_clear", irq_o, 1'b0);

        busy_i = 1'b1;
        axi_write(8'h00, 32'h1, 4'h1, 0, 0);
        axi_read(8'h04, 0, got);
        chk("status_busy_err_literal", got, 32'h5);
        pulse_done_i();
        axi_write(8'h04, 32'h2, 4'h1, 0, 1);
        axi_read(8'h04, 0, got);
        chk("status_set_wins_literal", got, 32'h7);
        axi_write(8'h04, 32'h6, 4'h1, -2, 0);
        busy_i = 1'b0;

        axi_read(8'h20, 0, got);
        chk("unmapped_rdata_literal", got, 32'h0);
        axi_write(8'h24, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axi_read(8'h1C, 0, got);
        chk("version_literal", got, 32'h0001_0000);

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(8, 63) << 2);
            else a = 8'($urandom_range(0, 7) << 2);
            a = a | 8'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (op <= 4) axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, 0);
            else if (op <= 7) axi_read(a, $urandom_range(0, 2), got);
            else if (op == 8) pulse_done_i();
            else begin busy_i = ~busy_i; tick(); end
        end
        busy_i = 1'b0;

        axi_write(8'h08, 32'hCAFE_F00D, 4'hF, 0, 0);
        bus.araddr = 8'h08;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("pre_reset_rvalid", bus.rvalid, 1'b1);
        bus.awaddr = 8'h10;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midreset_rvalid", bus.rvalid, 1'b0);
        chk("midreset_rdata", bus.rdata, 32'h0);
        chk("midreset_src", src_addr_o, 64'h0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("post_reset_arready", bus.arready, 1'b1);
        chk("post_reset_awready", bus.awready, 1'b1);
        chk("post_reset_wready", bus.wready, 1'b1);
        axi_read(8'h08, 0, got);
        axi_read(8'h00, 0, got);
        axi_write(8'h14, 32'h0BAD_0BAD, 4'hF, 1, 0);
        axi_read(8'h10, 0, got);
        axi_read(8'h14, 0, got);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
